// File: rtl/dct8_scale_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dct8_scale_stage
//  Description : Scaling stage for the 8-point DCT datapath. Arithmetic
//                right shift with optional round-half-up, output saturation
//                with a sticky overflow flag, valid/ready handshake through
//                a 2-entry skid buffer, and an end-of-block tag.
//  Revision    : 1.0  initial release
// ============================================================================
module dct8_scale_stage #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT_W   = 2,
   parameter int BLOCK_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_sample,
   input  logic [SHIFT_W-1:0]   shift_amt,
   input  logic                 round_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_sample,
   output logic                 out_last,
   output logic                 ovf_sticky,
   input  logic                 ovf_clear
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_cnt_w = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;

   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLOCK_LEN - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [SHIFT_W-1:0] c_shift_one = SHIFT_W'(1);

   // Arithmetic is carried one bit wider than the input so that the rounding
   // increment can never wrap the most positive input.
   localparam logic signed [IN_WIDTH:0] c_one = (IN_WIDTH + 1)'(1);

   // Largest / smallest representable output, sign-extended to IN_WIDTH+1.
   localparam logic signed [IN_WIDTH:0] c_max =
      {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [IN_WIDTH:0] c_min =
      {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [c_cnt_w-1:0]   r_cnt;

   logic                 r_m_valid;
   logic [OUT_WIDTH-1:0] r_m_sample;
   logic                 r_m_last;

   logic                 r_s_valid;
   logic [OUT_WIDTH-1:0] r_s_sample;
   logic                 r_s_last;

   logic                 r_ovf;

   // ------------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------------
   logic signed [IN_WIDTH:0] w_ext;
   logic signed [IN_WIDTH:0] w_rnd;
   logic signed [IN_WIDTH:0] w_t;
   logic signed [IN_WIDTH:0] w_r;
   logic                     w_sat_hi;
   logic                     w_sat_lo;
   logic                     w_sat;
   logic [OUT_WIDTH-1:0]     w_res;
   logic                     w_last;
   logic                     w_acc;
   logic                     w_take;

   // The skid register being empty is the only thing that gates acceptance,
   // so in_ready has no combinational path from in_valid or out_ready.
   assign in_ready = !r_s_valid;
   assign w_acc    = in_valid && in_ready;

   // M may be (re)loaded whenever it is empty or its content leaves this cycle.
   assign w_take   = !r_m_valid || out_ready;

   // The incoming sample closes a block when the counter sits on its last index.
   assign w_last   = (r_cnt == c_cnt_last);

   // Shift with optional round-half-up, then clamp to the output range.
   always_comb begin
      w_ext = {in_sample[IN_WIDTH-1], in_sample};
      w_rnd = '0;
      if (round_en && (shift_amt != '0)) begin
         w_rnd = c_one << (shift_amt - c_shift_one);
      end
      w_t      = w_ext + w_rnd;
      w_r      = w_t >>> shift_amt;
      w_sat_hi = (w_r > c_max);
      w_sat_lo = (w_r < c_min);
      w_sat    = w_sat_hi || w_sat_lo;
      if (w_sat_hi) begin
         w_res = c_max[OUT_WIDTH-1:0];
      end else if (w_sat_lo) begin
         w_res = c_min[OUT_WIDTH-1:0];
      end else begin
         w_res = w_r[OUT_WIDTH-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------------

   // Block position counter, advanced on every accepted sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_acc) begin
         r_cnt <= w_last ? '0 : (r_cnt + c_cnt_one);
      end
   end

   // Main output register: refilled from the skid first to keep FIFO order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m_valid  <= 1'b0;
         r_m_sample <= '0;
         r_m_last   <= 1'b0;
      end else if (w_take) begin
         if (r_s_valid) begin
            r_m_valid  <= 1'b1;
            r_m_sample <= r_s_sample;
            r_m_last   <= r_s_last;
         end else if (w_acc) begin
            r_m_valid  <= 1'b1;
            r_m_sample <= w_res;
            r_m_last   <= w_last;
         end else begin
            r_m_valid  <= 1'b0;
         end
      end
   end

   // Skid register: catches a new sample while M is stalled downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s_valid  <= 1'b0;
         r_s_sample <= '0;
         r_s_last   <= 1'b0;
      end else if (w_take) begin
         if (r_s_valid && w_acc) begin
            r_s_valid  <= 1'b1;
            r_s_sample <= w_res;
            r_s_last   <= w_last;
         end else begin
            r_s_valid  <= 1'b0;
         end
      end else if (w_acc) begin
         r_s_valid  <= 1'b1;
         r_s_sample <= w_res;
         r_s_last   <= w_last;
      end
   end

   // Sticky overflow: a saturating accept takes priority over a clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_acc && w_sat) begin
         r_ovf <= 1'b1;
      end else if (ovf_clear) begin
         r_ovf <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_valid  = r_m_valid;
   assign out_sample = r_m_sample;
   assign out_last   = r_m_last;
   assign ovf_sticky = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dct8_scale_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dct8_scale_stage
//  Description : Self-checking bench for dct8_scale_stage (OUT_WIDTH=12 so
//                that saturation is reachable). A queue-based model tracks
//                stage contents; directed table vectors plus hand-written
//                back-pressure, tagging and reset sequences, then random.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dct8_scale_stage;

   localparam int IN_W  = 16;
   localparam int OUT_W = 12;
   localparam int SH_W  = 2;
   localparam int BL    = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_sample;
   logic [SH_W-1:0]  shift_amt;
   logic             round_en;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_sample;
   logic             out_last;
   logic             ovf_sticky;
   logic             ovf_clear;

   always #5 clk = ~clk;

   dct8_scale_stage #(
      .IN_WIDTH  (IN_W),
      .OUT_WIDTH (OUT_W),
      .SHIFT_W   (SH_W),
      .BLOCK_LEN (BL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sample  (in_sample),
      .shift_amt  (shift_amt),
      .round_en   (round_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sample (out_sample),
      .out_last   (out_last),
      .ovf_sticky (ovf_sticky),
      .ovf_clear  (ovf_clear)
   );

   typedef struct {
      int val;
      bit last;
   } exp_t;

   typedef struct {
      int smp;
      int sh;
      bit rnd;
      int exp_val;
      bit exp_sat;
   } vec_t;

   exp_t mq[$];
   int   m_cnt;
   bit   m_ovf;
   int   got_v[$];
   bit   got_l[$];
   vec_t tbl[$];
   bit   last_acc;
   bit   chk_en;
   int   n_vec;
   int   n_err;

   // Reference scaling: plain integer arithmetic on the stated rules.
   function automatic void scale(input int smp, input int s, input bit rnd,
                                 output int val, output bit sat);
      int t;
      int r;
      int hi;
      int lo;
      t = smp;
      if (rnd && s > 0) t = t + (1 << (s - 1));
      r  = t >>> s;
      hi = (1 << (OUT_W - 1)) - 1;
      lo = -(1 << (OUT_W - 1));
      val = r;
      sat = 1'b0;
      if (r > hi) begin
         val = hi;
         sat = 1'b1;
      end else if (r < lo) begin
         val = lo;
         sat = 1'b1;
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input int smp, input int sh, input bit rnd,
                          input int e, input bit sat);
      vec_t v;
      v.smp = smp; v.sh = sh; v.rnd = rnd; v.exp_val = e; v.exp_sat = sat;
      tbl.push_back(v);
   endtask

   // One clock: check state at negedge, advance model at posedge, return +1.
   task automatic step();
      bit   acc;
      bit   xfer;
      int   v;
      bit   sat;
      exp_t e;
      @(negedge clk);
      if (chk_en && rst_n) begin
         chk("in_ready", int'(in_ready), int'(mq.size() < 2));
         chk("out_valid", int'(out_valid), int'(mq.size() > 0));
         if (mq.size() > 0) begin
            chk("out_sample", int'($signed(out_sample)), mq[0].val);
            chk("out_last", int'(out_last), int'(mq[0].last));
         end
         chk("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
      end
      acc  = rst_n && in_valid && (mq.size() < 2);
      xfer = rst_n && out_ready && (mq.size() > 0);
      if (xfer) begin
         got_v.push_back(int'($signed(out_sample)));
         got_l.push_back(out_last);
      end
      scale(int'($signed(in_sample)), int'(shift_amt), round_en, v, sat);
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
      end else begin
         if (xfer) void'(mq.pop_front());
         if (acc) begin
            e.val  = v;
            e.last = (m_cnt == BL - 1);
            mq.push_back(e);
            m_cnt = (m_cnt == BL - 1) ? 0 : m_cnt + 1;
         end
         if (acc && sat) m_ovf = 1'b1;
         else if (ovf_clear) m_ovf = 1'b0;
      end
      last_acc = acc;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      bit [5:0] pat;
      int       nxt;
      int       cyc;
      int       acc_cnt;

      n_vec = 0; n_err = 0; chk_en = 1'b0;
      m_cnt = 0; m_ovf = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; shift_amt = '0;
      round_en = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;

      // ---------------- reset state ----------------
      step();
      step();
      chk_en = 1'b1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sample", int'($signed(out_sample)), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_ovf", int'(ovf_sticky), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;

      // ---------------- table vectors ----------------
      add_vec(-3, 1, 0, -2, 0);
      add_vec( 3, 1, 0,  1, 0);
      add_vec( 5, 1, 0,  2, 0);
      add_vec(-3, 1, 1, -1, 0);
      add_vec( 3, 1, 1,  2, 0);
      add_vec( 5, 1, 1,  3, 0);
      add_vec( 100, 0, 0,  100, 0);
      add_vec(  -7, 0, 1,   -7, 0);
      add_vec( 32767, 1, 1,  2047, 1);
      add_vec(-32768, 1, 0, -2048, 1);
      add_vec( 2047, 0, 0,  2047, 0);
      add_vec( 2048, 0, 0,  2047, 1);
      add_vec(-2049, 0, 0, -2048, 1);
      add_vec(    7, 3, 1,     1, 0);
      add_vec(   -5, 2, 1,    -1, 0);
      add_vec(   -6, 2, 0,    -2, 0);
      add_vec( 4095, 1, 1,  2047, 1);
      add_vec( 4094, 1, 1,  2047, 0);

      out_ready = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         in_valid  = 1'b1;
         in_sample = IN_W'(tbl[i].smp);
         shift_amt = SH_W'(tbl[i].sh);
         round_en  = tbl[i].rnd;
         step();
         in_valid = 1'b0;
         chk("tbl_valid", int'(out_valid), 1);
         chk("tbl_sample", int'($signed(out_sample)), tbl[i].exp_val);
         chk("tbl_ovf", int'(ovf_sticky), int'(tbl[i].exp_sat));
         ovf_clear = 1'b1;
         step();
         ovf_clear = 1'b0;
      end

      // ---------------- ovf set beats clear ----------------
      in_valid = 1'b1; in_sample = 16'sd32767; shift_amt = 2'd1; round_en = 1'b1;
      step();
      in_valid = 1'b0;
      chk("ovf_set", int'(ovf_sticky), 1);
      in_valid = 1'b1; ovf_clear = 1'b1;
      step();
      in_valid = 1'b0; ovf_clear = 1'b0;
      chk("ovf_set_wins", int'(ovf_sticky), 1);
      ovf_clear = 1'b1;
      step();
      ovf_clear = 1'b0;
      chk("ovf_clear", int'(ovf_sticky), 0);
      step();

      // ---------------- back-pressure 1..20 ----------------
      got_v.delete(); got_l.delete();
      pat = 6'b101001;
      shift_amt = '0; round_en = 1'b0;
      nxt = 1; cyc = 0;
      while (got_v.size() < 20 && cyc < 400) begin
         out_ready = pat[cyc % 6];
         in_valid  = (nxt <= 20);
         in_sample = IN_W'(nxt);
         step();
         if (last_acc) nxt++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("bp_count", got_v.size(), 20);
      for (int i = 0; i < got_v.size(); i++) chk("bp_order", got_v[i], i + 1);

      // At most two accepts once out_ready falls with an empty stage.
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0; in_valid = 1'b1; acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         in_sample = IN_W'(100 + i);
         step();
         if (last_acc) acc_cnt++;
      end
      chk("stall_accepts", acc_cnt, 2);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      // ---------------- block tagging with random stalls ----------------
      do_reset();
      got_v.delete(); got_l.delete();
      nxt = 0; cyc = 0;
      while (got_v.size() < 24 && cyc < 800) begin
         out_ready = ($urandom_range(0, 2) != 0);
         in_valid  = (nxt < 24) && ($urandom_range(0, 3) != 0);
         in_sample = IN_W'($urandom);
         shift_amt = SH_W'($urandom);
         round_en  = 1'($urandom);
         step();
         if (last_acc) nxt++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("tag_count", got_l.size(), 24);
      for (int i = 0; i < got_l.size(); i++)
         chk("tag_last", int'(got_l[i]), int'(((i + 1) % BL) == 0));

      // ---------------- reset with M and S full, cnt=5 ----------------
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; shift_amt = '0; round_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_sample = IN_W'(i + 1);
         step();
      end
      out_ready = 1'b0;
      in_sample = IN_W'(5);
      step();
      chk("pre_rst_in_ready", int'(in_ready), 0);
      chk("pre_rst_out_valid", int'(out_valid), 1);
      in_sample = IN_W'(9);
      rst_n = 1'b0;
      step();
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1; out_ready = 1'b1;
      got_v.delete(); got_l.delete();
      for (int i = 0; i < 8; i++) begin
         in_sample = IN_W'(50 + i);
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      chk("post_rst_count", got_l.size(), 8);
      for (int i = 0; i < got_l.size(); i++)
         chk("post_rst_last", int'(got_l[i]), int'(i == 7));

      // ---------------- random traffic ----------------
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_sample = IN_W'($urandom);
         shift_amt = SH_W'($urandom);
         round_en  = 1'($urandom);
         ovf_clear = ($urandom_range(0, 15) == 0);
         step();
      end
      in_valid = 1'b0; ovf_clear = 1'b0; out_ready = 1'b1;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
